// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the pipeline stages.
//   - ALU function codes carried on the ID/EX aluop field
//   - datapath width and register-index width
//   - bundled writeback/memory control bits
//   - squash FSM state encoding used by the execute stage
package pipeline_pkg;

    localparam int DW = 32;
    localparam int RW = 6;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_NEG   = 3'b011;
    localparam logic [2:0] ALU_PASSA = 3'b100;

    typedef struct packed {
        logic regw;
        logic wai;
        logic memw;
        logic memr;
    } ctrl_t;

    typedef enum logic {
        SQ_IDLE  = 1'b0,
        SQ_FLUSH = 1'b1
    } sq_state_e;

endpackage

// File: rtl/buffer_EX_WB.sv
// buffer_EX_WB
//   EX/WB pipeline register bank. Captures the execute-stage results every
//   cycle; all fields clear on asynchronous reset.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   alu_p0..ctrl_p0 execute-stage values (ALU result, store data, PC,
//                   destination index, squash-gated controls, redirect pulse)
//   alu_p1..taken_p1 registered copies driven to writeback and fetch
module buffer_EX_WB
    import pipeline_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] alu_p0,
    input  logic [DW-1:0] rd2_p0,
    input  logic [DW-1:0] pc_p0,
    input  logic [RW-1:0] rd_p0,
    input  ctrl_t         ctrl_p0,
    input  logic          taken_p0,
    output logic [DW-1:0] alu_p1,
    output logic [DW-1:0] rd2_p1,
    output logic [DW-1:0] pc_p1,
    output logic [RW-1:0] rd_p1,
    output ctrl_t         ctrl_p1,
    output logic          taken_p1
);

    // ---- EX -> WB boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_p1   <= '0;
            rd2_p1   <= '0;
            pc_p1    <= '0;
            rd_p1    <= '0;
            ctrl_p1  <= '0;
            taken_p1 <= 1'b0;
        end else begin
            alu_p1   <= alu_p0;
            rd2_p1   <= rd2_p0;
            pc_p1    <= pc_p0;
            rd_p1    <= rd_p0;
            ctrl_p1  <= ctrl_p0;
            taken_p1 <= taken_p0;
        end
    end

endmodule

// File: rtl/stage3.sv
// stage3
//   Execute stage. Consumes the ID/EX bundle, evaluates the ALU, resolves
//   jumps and flag-based branches against the internal Z/N flag register,
//   squashes the FLUSH_SLOTS younger instructions after a taken redirect,
//   and registers everything into the EX/WB buffer.
// Ports:
//   clk, rst_n                     clock / asynchronous active-low reset
//   in_imm, in_rd1, in_rd2, in_PC  operands and PC from ID/EX
//   in_rd                          destination register index
//   in_brz, in_brn, in_j           branch-if-zero / branch-if-negative / jump
//   in_regw, in_wai, in_memw, in_memr  writeback/memory controls
//   in_alusrc, in_aluop            B-operand select and ALU function
//   out_alu, out_rd2, out_PC, out_rd   registered results to writeback
//   out_regw, out_wai, out_memw, out_memr  registered, squash-gated controls
//   out_taken, out_target          one-cycle redirect pulse and its PC
//   out_z, out_n                   current flag register
module stage3
    import pipeline_pkg::*;
#(
    parameter int FLUSH_SLOTS = 2,
    parameter int DW          = pipeline_pkg::DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_imm,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] in_rd1,
    input  logic [DW-1:0] in_rd2,
    input  logic [DW-1:0] in_PC,
    input  logic          in_brz,
    input  logic          in_brn,
    input  logic          in_j,
    input  logic          in_regw,
    input  logic          in_wai,
    input  logic          in_memw,
    input  logic          in_memr,
    input  logic          in_alusrc,
    input  logic [2:0]    in_aluop,
    output logic [DW-1:0] out_alu,
    output logic [DW-1:0] out_rd2,
    output logic [DW-1:0] out_PC,
    output logic [RW-1:0] out_rd,
    output logic          out_regw,
    output logic          out_wai,
    output logic          out_memw,
    output logic          out_memr,
    output logic          out_taken,
    output logic [DW-1:0] out_target,
    output logic          out_z,
    output logic          out_n
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_SLOTS);

    // Wrap-around ALU; overflow is intentionally ignored.
    function automatic logic signed [DW-1:0] alu_eval(
        input logic [2:0]           op,
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        case (op)
            ALU_PASSB: return b;
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_NEG:   return -a;
            ALU_PASSA: return a;
            default:   return '0;
        endcase
    endfunction

    sq_state_e            sq_state, sq_state_nxt;
    logic [1:0]           sq_cnt, sq_cnt_nxt;

    logic                 z_q, n_q;
    logic [DW-1:0]        target_q;

    logic signed [DW-1:0] a_p0, b_p0, alu_p0;
    logic                 vld_p0;
    logic                 flag_op_p0;
    logic                 taken_p0;
    ctrl_t                ctrl_p0;
    ctrl_t                ctrl_p1;

    // ---- ID/EX -> EX: operand select, ALU, branch resolution ----
    assign a_p0   = in_rd1;
    assign b_p0   = in_alusrc ? in_imm : in_rd2;
    assign alu_p0 = alu_eval(in_aluop, a_p0, b_p0);

    // An instruction in a squash slot is on the wrong path.
    assign vld_p0 = (sq_state == SQ_IDLE);

    assign flag_op_p0 = (in_aluop == ALU_ADD) || (in_aluop == ALU_SUB) ||
                        (in_aluop == ALU_NEG);

    // Every branch flavour redirects to in_rd1, so the j > brz > brn
    // priority collapses to a plain OR; flags are the pre-instruction values.
    assign taken_p0 = vld_p0 & (in_j | (in_brz & z_q) | (in_brn & n_q));

    assign ctrl_p0 = vld_p0 ? ctrl_t'{regw: in_regw, wai: in_wai,
                                      memw: in_memw, memr: in_memr}
                            : ctrl_t'('0);

    // Squash FSM: a taken redirect arms FLUSH_SLOTS squash cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_state <= SQ_IDLE;
            sq_cnt   <= '0;
        end else begin
            sq_state <= sq_state_nxt;
            sq_cnt   <= sq_cnt_nxt;
        end
    end

    always_comb begin
        sq_state_nxt = sq_state;
        sq_cnt_nxt   = sq_cnt;
        case (sq_state)
            SQ_IDLE: begin
                if (taken_p0) begin
                    sq_state_nxt = SQ_FLUSH;
                    sq_cnt_nxt   = FLUSH_INIT;
                end
            end
            SQ_FLUSH: begin
                sq_cnt_nxt = sq_cnt - 2'd1;
                if (sq_cnt == 2'd1) begin
                    sq_state_nxt = SQ_IDLE;
                end
            end
            default: begin
                sq_state_nxt = SQ_IDLE;
                sq_cnt_nxt   = '0;
            end
        endcase
    end

    // ---- EX -> WB: flag register, redirect target, result buffer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (vld_p0 && flag_op_p0) begin
            z_q <= (alu_p0 == '0);
            n_q <= alu_p0[DW-1];
        end
    end

    // Target holds its last value between redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
        end else if (taken_p0) begin
            target_q <= in_rd1;
        end
    end

    buffer_EX_WB #(
        .DW (DW)
    ) u_buffer_EX_WB (
        .clk      (clk),
        .rst_n    (rst_n),
        .alu_p0   (alu_p0),
        .rd2_p0   (in_rd2),
        .pc_p0    (in_PC),
        .rd_p0    (in_rd),
        .ctrl_p0  (ctrl_p0),
        .taken_p0 (taken_p0),
        .alu_p1   (out_alu),
        .rd2_p1   (out_rd2),
        .pc_p1    (out_PC),
        .rd_p1    (out_rd),
        .ctrl_p1  (ctrl_p1),
        .taken_p1 (out_taken)
    );

    assign out_regw   = ctrl_p1.regw;
    assign out_wai    = ctrl_p1.wai;
    assign out_memw   = ctrl_p1.memw;
    assign out_memr   = ctrl_p1.memr;
    assign out_target = target_q;
    assign out_z      = z_q;
    assign out_n      = n_q;

endmodule

// File: tb/tb_stage3.sv
module tb_stage3;

    localparam int FLUSH = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_imm, in_rd1, in_rd2, in_PC;
    logic [5:0]  in_rd;
    logic        in_brz, in_brn, in_j;
    logic        in_regw, in_wai, in_memw, in_memr;
    logic        in_alusrc;
    logic [2:0]  in_aluop;
    logic [31:0] out_alu, out_rd2, out_PC, out_target;
    logic [5:0]  out_rd;
    logic        out_regw, out_wai, out_memw, out_memr;
    logic        out_taken, out_z, out_n;

    stage3 #(.FLUSH_SLOTS(FLUSH), .DW(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .in_rd1     (in_rd1),
        .in_rd2     (in_rd2),
        .in_PC      (in_PC),
        .in_brz     (in_brz),
        .in_brn     (in_brn),
        .in_j       (in_j),
        .in_regw    (in_regw),
        .in_wai     (in_wai),
        .in_memw    (in_memw),
        .in_memr    (in_memr),
        .in_alusrc  (in_alusrc),
        .in_aluop   (in_aluop),
        .out_alu    (out_alu),
        .out_rd2    (out_rd2),
        .out_PC     (out_PC),
        .out_rd     (out_rd),
        .out_regw   (out_regw),
        .out_wai    (out_wai),
        .out_memw   (out_memw),
        .out_memr   (out_memr),
        .out_taken  (out_taken),
        .out_target (out_target),
        .out_z      (out_z),
        .out_n      (out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] target;
        logic [5:0]  rd;
        logic [3:0]  ctrl;
        logic        taken;
        logic        z;
        logic        n;
        logic        squashed;
    } exp_t;

    exp_t sb[$];

    int passed = 0;
    int total  = 0;

    // reference model state
    logic        m_z, m_n;
    logic [31:0] m_t;
    int          m_cnt;
    logic [31:0] pc_ctr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic clear_inputs();
        in_imm = '0; in_rd1 = '0; in_rd2 = '0;
        in_brz = 0; in_brn = 0; in_j = 0;
        in_regw = 0; in_wai = 0; in_memw = 0; in_memr = 0;
        in_alusrc = 0; in_aluop = 3'd0;
    endtask

    task automatic model_reset();
        m_z = 0; m_n = 0; m_t = '0; m_cnt = 0;
    endtask

    // Drive one instruction (fields already set), predict, clock, compare.
    task automatic issue(input string tag);
        exp_t        e;
        logic        sq;
        logic        tk;
        logic [31:0] b;
        logic [31:0] r;
        in_PC  = pc_ctr;
        in_rd  = pc_ctr[7:2];
        pc_ctr = pc_ctr + 32'd4;
        sq = (m_cnt != 0);
        b  = in_alusrc ? in_imm : in_rd2;
        case (in_aluop)
            3'd0:    r = b;
            3'd1:    r = in_rd1 + b;
            3'd2:    r = in_rd1 - b;
            3'd3:    r = 32'd0 - in_rd1;
            3'd4:    r = in_rd1;
            default: r = 32'd0;
        endcase
        tk = !sq && (in_j || (in_brz && m_z) || (in_brn && m_n));
        if (!sq && (in_aluop == 3'd1 || in_aluop == 3'd2 || in_aluop == 3'd3)) begin
            m_z = (r == 32'd0);
            m_n = r[31];
        end
        if (tk) m_t = in_rd1;
        if (sq) m_cnt = m_cnt - 1;
        else if (tk) m_cnt = FLUSH;
        e.alu = r; e.rd2 = in_rd2; e.pc = in_PC; e.rd = in_rd;
        e.ctrl = sq ? 4'b0 : {in_regw, in_wai, in_memw, in_memr};
        e.taken = tk; e.target = m_t; e.z = m_z; e.n = m_n; e.squashed = sq;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".ctrl"}, {28'd0, out_regw, out_wai, out_memw, out_memr}, {28'd0, e.ctrl});
        chk({tag, ".taken"}, {31'd0, out_taken}, {31'd0, e.taken});
        chk({tag, ".target"}, out_target, e.target);
        chk({tag, ".z"}, {31'd0, out_z}, {31'd0, e.z});
        chk({tag, ".n"}, {31'd0, out_n}, {31'd0, e.n});
        if (!e.squashed) begin
            chk({tag, ".alu"}, out_alu, e.alu);
            chk({tag, ".rd2"}, out_rd2, e.rd2);
            chk({tag, ".pc"}, out_PC, e.pc);
            chk({tag, ".rd"}, {26'd0, out_rd}, {26'd0, e.rd});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".alu"}, out_alu, 32'd0);
        chk({tag, ".rd2"}, out_rd2, 32'd0);
        chk({tag, ".pc"}, out_PC, 32'd0);
        chk({tag, ".rd"}, {26'd0, out_rd}, 32'd0);
        chk({tag, ".ctrl"}, {28'd0, out_regw, out_wai, out_memw, out_memr}, 32'd0);
        chk({tag, ".taken"}, {31'd0, out_taken}, 32'd0);
        chk({tag, ".target"}, out_target, 32'd0);
        chk({tag, ".zn"}, {30'd0, out_z, out_n}, 32'd0);
    endtask

    initial begin
        pc_ctr = 32'h100;
        model_reset();
        clear_inputs();
        in_PC = '0; in_rd = '0;

        // reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ALU ops
        clear_inputs(); in_aluop = 3'd1; in_rd1 = 5; in_rd2 = 7; in_regw = 1;
        issue("add");
        chk("add.val", out_alu, 32'd12);
        clear_inputs(); in_aluop = 3'd2; in_rd1 = 3; in_rd2 = 3; in_wai = 1;
        issue("sub");
        chk("sub.z", {31'd0, out_z}, 32'd1);
        clear_inputs(); in_aluop = 3'd3; in_rd1 = 1; in_memr = 1;
        issue("neg");
        chk("neg.val", out_alu, 32'hFFFF_FFFF);
        chk("neg.n", {31'd0, out_n}, 32'd1);
        clear_inputs(); in_aluop = 3'd4; in_rd1 = 32'h1234_5678; in_rd2 = 32'hAA;
        issue("passa");
        clear_inputs(); in_aluop = 3'd0; in_rd1 = 32'h1; in_rd2 = 32'hBEEF; in_memw = 1;
        issue("passb");
        clear_inputs(); in_aluop = 3'd7; in_rd1 = 32'h55; in_rd2 = 32'h66;
        issue("op7");

        // immediate select and 32-bit wrap
        clear_inputs(); in_aluop = 3'd1; in_alusrc = 1; in_imm = 32'hFFFF_FFFF;
        in_rd2 = 9; in_rd1 = 1;
        issue("addimm");
        chk("addimm.val", out_alu, 32'd0);

        // BRZ taken after SUB 4-4, two squashed slots, then normal
        clear_inputs(); in_aluop = 3'd2; in_rd1 = 4; in_rd2 = 4;
        issue("sub44");
        clear_inputs(); in_brz = 1; in_rd1 = 32'h40;
        issue("brz");
        chk("brz.target", out_target, 32'h40);
        chk("brz.pulse", {31'd0, out_taken}, 32'd1);
        clear_inputs(); in_aluop = 3'd1; in_rd1 = 8; in_rd2 = 8; in_regw = 1; in_memw = 1;
        issue("slot1");
        chk("slot1.pulse_gone", {31'd0, out_taken}, 32'd0);
        clear_inputs(); in_aluop = 3'd3; in_rd1 = 2; in_regw = 1; in_memw = 1;
        issue("slot2");
        clear_inputs(); in_aluop = 3'd1; in_rd1 = 1; in_rd2 = 2; in_regw = 1; in_memw = 1;
        issue("after");
        chk("after.regw", {31'd0, out_regw}, 32'd1);

        // not-taken BRN with N=0, and J+BRZ with Z=0
        clear_inputs(); in_brn = 1; in_rd1 = 32'h99;
        issue("brn_nt");
        clear_inputs(); in_aluop = 3'd1; in_rd1 = 3; in_rd2 = 3; in_regw = 1;
        issue("nosquash");
        clear_inputs(); in_j = 1; in_brz = 1; in_rd1 = 32'h80;
        issue("jbrz");
        chk("jbrz.target", out_target, 32'h80);

        // squash isolation: squashed SUB 2-2 must not set Z, squashed BRZ no redirect
        clear_inputs(); in_aluop = 3'd2; in_rd1 = 2; in_rd2 = 2; in_regw = 1;
        issue("sq_sub");
        chk("sq_sub.z", {31'd0, out_z}, 32'd0);
        clear_inputs(); in_brz = 1; in_rd1 = 32'hC0;
        issue("sq_brz");
        clear_inputs(); in_aluop = 3'd4; in_rd1 = 32'h77; in_regw = 1;
        issue("post_sq");
        chk("post_sq.target", out_target, 32'h80);

        // reset during a squash
        clear_inputs(); in_aluop = 3'd3; in_rd1 = 5;
        issue("neg5");
        clear_inputs(); in_j = 1; in_rd1 = 32'h200;
        issue("j_rst");
        clear_inputs(); in_aluop = 3'd1; in_rd1 = 9; in_rd2 = 9; in_regw = 1;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs(); in_aluop = 3'd1; in_rd1 = 1; in_rd2 = 1; in_regw = 1;
        issue("rst_add");
        chk("rst_add.val", out_alu, 32'd2);
        chk("rst_add.regw", {31'd0, out_regw}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stage3.md
Name: stage3

Overview:
- Execute stage of the 5-stage pipeline. Consumer end of the ID/EX interface driven by the decode stage.
- Takes decoded operands and control bits, performs the ALU operation, and resolves jumps and flag-based branches against an internal Z/N flag register.
- Squashes wrong-path instructions after a taken branch.
- Registers the results into the EX/WB buffer that feeds writeback, which returns `writedata`/`rdi` to decode.

Parameters:
- `FLUSH_SLOTS`, 2: number of younger instructions squashed after a taken branch/jump (1..3).
- `DW`, 32: datapath width.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `in_imm` input 32: sign-extended immediate from ID/EX.
- `in_rd` input 6: destination register index.
- `in_rd1` input 32: rs operand (A; also jump/branch target).
- `in_rd2` input 32: rt operand (store data / B).
- `in_PC` input 32: PC value from ID/EX (SVPC result).
- `in_brz`, `in_brn`, `in_j` input 1 each: branch-if-zero, branch-if-negative, jump.
- `in_regw`, `in_wai`, `in_memw`, `in_memr` input 1 each: writeback/memory controls, passed through.
- `in_alusrc` input 1: B = 1 ? `in_imm` : `in_rd2`.
- `in_aluop` input 3: ALU function.
- `out_alu` output 32: registered ALU result.
- `out_rd2` output 32: registered store data.
- `out_PC` output 32: registered PC passthrough.
- `out_rd` output 6: registered destination index.
- `out_regw`, `out_wai`, `out_memw`, `out_memr` output 1 each: registered, squash-gated controls.
- `out_taken` output 1: one-cycle redirect pulse to fetch.
- `out_target` output 32: redirect PC, valid while `out_taken`=1.
- `out_z`, `out_n` output 1: current flag register (debug/visibility).

Behaviour:
- **Reset** (`rst_n`=0, asynchronous):
  - All outputs 0.
  - Flags Z=0, N=0.
  - Squash counter 0.
  - Reset mid-squash abandons the squash. The first instruction after release executes normally.
- **Latency:** every output is registered; an instruction entering EX at edge k appears on `out_*` after edge k+1. No stalls; one instruction per cycle.
- **ALU** (A=`in_rd1`, B per `in_alusrc`; 32-bit, wrap-around, no overflow detection):
  - 000 pass B
  - 001 A+B
  - 010 A-B
  - 011 -A (two's complement)
  - 100 pass A
  - 101..111 result 0
- **Flags:**
  - Updated at the edge only for aluop 001/010/011 and only when not squashed.
  - Z = (result==0); N = result[31].
  - Other ops and squashed instructions leave flags unchanged.
- **Branch resolution** (uses the flag register value before the current instruction; branches use aluop 000 and never update flags):
  - Priority `in_j` > `in_brz` > `in_brn`.
  - taken = j | (brz & Z) | (brn & N).
  - target = `in_rd1`.
  - On taken: `out_taken`=1 and `out_target`=`in_rd1` for exactly one cycle; otherwise `out_taken`=0 and `out_target` holds its previous value.
- **Squash** (state: IDLE / SQUASH(count)):
  - A taken branch in IDLE loads count=`FLUSH_SLOTS`.
  - Each following cycle the instruction in EX is squashed and count decrements; SQUASH→IDLE when count reaches 0.
  - A squashed instruction:
    - forces `out_regw`/`out_wai`/`out_memw`/`out_memr`/`out_taken` to 0;
    - never updates flags;
    - has its branch bits ignored, so there is no nested redirect.
  - Data fields (`out_alu`, `out_rd`, etc.) still update; they are don't-care because the controls are zero.
- **Passthrough:** `out_rd2`, `out_PC`, `out_rd` are registered copies of their inputs.

Decomposition:
- Shared package `pipeline_pkg`:
  - `ALU_PASSB`, `ALU_ADD`, `ALU_SUB`, `ALU_NEG`, `ALU_PASSA` (3-bit) constants;
  - `DW`;
  - register index width 6.
- One natural sub-module: `buffer_EX_WB`, the async-reset register bank for `out_alu`/`out_rd2`/`out_PC`/`out_rd`/controls. ALU, flags and squash FSM stay in `stage3`.

Test Plan:
- **ALU ops:**
  - aluop=001, alusrc=0, rd1=5, rd2=7, regw=1 → next cycle `out_alu`=12, `out_regw`=1, Z=0, N=0.
  - aluop=010, rd1=3, rd2=3 → `out_alu`=0, Z=1.
  - aluop=011, rd1=1 → `out_alu`=0xFFFFFFFF, N=1.
- **Immediate and wrap:** alusrc=1, imm=0xFFFFFFFF, rd2=9, rd1=1, aluop=001 → `out_alu`=0, Z=1, proving B=imm and the 32-bit wrap.
- **BRZ with flags:**
  - SUB 4-4 then brz=1, rd1=0x40 → `out_taken` pulses 1 cycle, `out_target`=0x40.
  - The next 2 instructions (regw=1, memw=1) emerge with all controls 0.
  - The third instruction executes normally.
- **Not-taken and priority:**
  - brn=1 with N=0 → `out_taken`=0, no squash.
  - j=1 and brz=1 with Z=0 → taken to rd1.
- **Squash isolation:** taken J followed by a squashed SUB 2-2 and then BRZ → the SUB does not set Z, the squashed BRZ causes no redirect, and flags are unchanged.
- **Reset mid-squash:** assert `rst_n`=0 one cycle after a taken jump → outputs/flags 0 immediately. After release, ADD 1+1 with regw=1 yields `out_regw`=1, `out_alu`=2.
